// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the weighted round-robin bus scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_sched_pkg;

    // Scheduler sequencing states; each packet walks ARB -> POP -> ROUTE.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2
    } state_e;

    // Destination header occupies the top HDR_W bits of every packet.
    localparam int HDR_W = 8;

    // Header value that fans a packet out to every device except the sender.
    localparam logic [HDR_W-1:0] BCAST_ID = 8'hFF;

    // Widest packet the header helper accepts; callers zero-extend into it.
    localparam int PKT_MAX_W = 256;

    // Extract the destination header from a packet that is pkt_w bits wide.
    function automatic logic [HDR_W-1:0] hdr_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int                   pkt_w);
        return HDR_W'(pkt >> (pkt_w - HDR_W));
    endfunction

endpackage

// File: rtl/bus_wrr_scheduler_rr_picker.sv
// Rotating-priority search: first set request at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_picker #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    input  logic [7:0]   ptr,
    output logic [7:0]   gnt_idx,
    output logic         any_req
);

    logic [N-1:0] w_rot;
    int           w_sum;

    // Rotate requests so ptr lands on bit 0, take the lowest set bit, map back.
    always_comb begin
        w_rot   = N'({req, req} >> ptr);
        any_req = 1'b0;
        w_sum   = 0;
        gnt_idx = '0;
        // Descending scan so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                any_req = 1'b1;
                w_sum   = int'(ptr) + k;
            end
        end
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        gnt_idx = 8'(w_sum);
    end

endmodule

// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin scheduler moving head packets from device FIFOs to destination FIFOs.
// Latency: 3 cycles per packet (ARB, POP, ROUTE), no overlap between packets.
// Backpressure: a device is only served while its pndng flag is set; destinations are never stalled.
module bus_wrr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int               pckg_sz  = 24,
    parameter int               drvrs    = 16,
    parameter logic [HDR_W-1:0] bcast_id = BCAST_ID,
    parameter int               wght_w   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    input  logic [drvrs-1:0][wght_w-1:0]    cfg_wght,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic [7:0]                      grant_id,
    output logic                            busy,
    output logic [15:0]                     drop_cnt
);

    localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    // Registered state
    state_e              r_state;
    logic [7:0]          r_rr_ptr;
    logic [wght_w-1:0]   r_burst_cnt;
    logic                r_burst_cont;
    logic [7:0]          r_grant_id;
    logic [drvrs-1:0]    r_pop;
    logic [drvrs-1:0]    r_push;
    logic [pckg_sz-1:0]  r_pkt_q;
    logic                r_busy;
    logic [15:0]         r_drop_cnt;

    // Next-state values
    state_e              w_state_nxt;
    logic [7:0]          w_rr_nxt;
    logic [wght_w-1:0]   w_burst_nxt;
    logic                w_cont_nxt;
    logic [7:0]          w_grant_nxt;
    logic [drvrs-1:0]    w_pop_nxt;
    logic [drvrs-1:0]    w_push_nxt;
    logic [pckg_sz-1:0]  w_pkt_nxt;
    logic                w_busy_nxt;
    logic [15:0]         w_drop_nxt;

    // Helpers around the current grant
    logic [7:0]          w_pick_idx;
    logic                w_any_req;
    logic [IDX_W-1:0]    w_gidx;
    logic                w_pnd_g;
    logic [pckg_sz-1:0]  w_head;
    logic [HDR_W-1:0]    w_dest;
    logic [wght_w-1:0]   w_wght_eff;
    logic                w_burst_more;

    rr_picker #(
        .N (drvrs)
    ) u_rr_picker (
        .req     (pndng),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .any_req (w_any_req)
    );

    // Per-grant views: head packet, its header, pending flag and effective weight.
    always_comb begin
        w_gidx       = r_grant_id[IDX_W-1:0];
        w_pnd_g      = pndng[w_gidx];
        w_head       = D_pop[w_gidx];
        w_dest       = hdr_of(PKT_MAX_W'(w_head), pckg_sz);
        w_wght_eff   = (cfg_wght[w_gidx] == '0) ? wght_w'(1) : cfg_wght[w_gidx];
        // Another packet fits in this burst only if the weight allows and the FIFO has one.
        w_burst_more = (({1'b0, r_burst_cnt} + (wght_w + 1)'(1)) < {1'b0, w_wght_eff})
                       && w_pnd_g;
    end

    // Next-state and next-output decode for the ARB/POP/ROUTE sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = r_burst_cnt;
        w_cont_nxt  = r_burst_cont;
        w_grant_nxt = r_grant_id;
        w_pop_nxt   = '0;
        w_push_nxt  = '0;
        w_pkt_nxt   = r_pkt_q;
        w_busy_nxt  = 1'b0;
        w_drop_nxt  = r_drop_cnt;

        case (r_state)
            ARB: begin
                w_cont_nxt = 1'b0;
                if (r_burst_cont && w_pnd_g) begin
                    // Burst continues on the same device without re-arbitration.
                    w_pop_nxt[w_gidx] = 1'b1;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = POP;
                end else begin
                    // A burst whose device ran dry is abandoned here.
                    w_burst_nxt = '0;
                    if (w_any_req) begin
                        w_grant_nxt                      = w_pick_idx;
                        w_pop_nxt[w_pick_idx[IDX_W-1:0]] = 1'b1;
                        w_busy_nxt                       = 1'b1;
                        w_state_nxt                      = POP;
                    end else begin
                        w_grant_nxt = '0;
                    end
                end
            end

            POP: begin
                // FIFO advances on this edge; capture its head and decide the push now
                // so push and D_push appear together, registered, during ROUTE.
                w_pkt_nxt   = w_head;
                w_busy_nxt  = 1'b1;
                w_state_nxt = ROUTE;
                if (w_dest == bcast_id) begin
                    w_push_nxt         = '1;
                    w_push_nxt[w_gidx] = 1'b0;
                end else if ((int'(w_dest) < drvrs) && (w_dest != r_grant_id)) begin
                    w_push_nxt[w_dest[IDX_W-1:0]] = 1'b1;
                end else begin
                    w_drop_nxt = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : r_drop_cnt + 16'd1;
                end
            end

            ROUTE: begin
                w_pkt_nxt   = '0;
                w_state_nxt = ARB;
                if (w_burst_more) begin
                    w_burst_nxt = r_burst_cnt + wght_w'(1);
                    w_cont_nxt  = 1'b1;
                end else begin
                    w_burst_nxt = '0;
                    w_cont_nxt  = 1'b0;
                    w_rr_nxt    = (int'(r_grant_id) >= drvrs - 1) ? 8'd0 : r_grant_id + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight packet silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_burst_cont <= 1'b0;
            r_grant_id   <= '0;
            r_pop        <= '0;
            r_push       <= '0;
            r_pkt_q      <= '0;
            r_busy       <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_burst_cont <= w_cont_nxt;
            r_grant_id   <= w_grant_nxt;
            r_pop        <= w_pop_nxt;
            r_push       <= w_push_nxt;
            r_pkt_q      <= w_pkt_nxt;
            r_busy       <= w_busy_nxt;
            r_drop_cnt   <= w_drop_nxt;
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign D_push   = r_pkt_q;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bus_wrr_scheduler.sv
// Scoreboard bench for bus_wrr_scheduler: device FIFO model feeds the DUT, expected grants queued.
// Latency: checks pop one cycle after pndng rises and push one cycle after pop.
// Backpressure: FIFO model advances only on an observed pop strobe.
`timescale 1ns/1ps
module tb_bus_wrr_scheduler;

    localparam int PW = 24;
    localparam int ND = 16;
    localparam int WW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [ND-1:0]          pndng;
    logic [ND-1:0][PW-1:0]  d_pop;
    logic [ND-1:0][WW-1:0]  cfg_wght;
    logic [ND-1:0]          pop;
    logic [ND-1:0]          push;
    logic [PW-1:0]          d_push;
    logic [7:0]             grant_id;
    logic                   busy;
    logic [15:0]            drop_cnt;

    typedef struct {
        int          dev;
        logic [15:0] mask;
        logic [23:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] dq[ND][64];
    int          dq_rd[ND];
    int          dq_wr[ND];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   pnd_on_cyc = 0;
    int   last_pop_cyc = -1;
    logic chk_gap = 1'b0;
    logic chk_lat = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_wrr_scheduler #(
        .pckg_sz  (PW),
        .drvrs    (ND),
        .bcast_id (8'hFF),
        .wght_w   (WW)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .cfg_wght (cfg_wght),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_mask(input int dev, input logic [7:0] dest);
        logic [15:0] m;
        m = '0;
        if (dest == 8'hFF) begin
            m      = '1;
            m[dev] = 1'b0;
        end else if (int'(dest) < ND && int'(dest) != dev) begin
            m[dest[3:0]] = 1'b1;
        end
        return m;
    endfunction

    task automatic load_pkt(input int dev, input logic [23:0] p);
        dq[dev][dq_wr[dev] % 64] = p;
        dq_wr[dev]++;
    endtask

    task automatic expect_pkt(input int dev, input logic [23:0] p);
        exp_t e;
        e.dev  = dev;
        e.mask = model_mask(dev, p[23:16]);
        e.data = p;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) @(posedge clk);
        check_val(tag, exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Monitor at negedge, then device FIFO model update just after posedge.
    initial begin
        logic [ND-1:0] snap;
        logic [ND-1:0] prev_pop;
        logic [ND-1:0] old_pnd;
        logic          prev_route;
        exp_t          e;
        pndng      = '0;
        d_pop      = '0;
        prev_pop   = '0;
        prev_route = 1'b0;
        forever begin
            @(negedge clk);
            snap = pop;
            if (prev_route) check_val("busy_arb", busy, 0);
            prev_route = 1'b0;
            if (prev_pop != '0) begin
                check_val("pop_in_route", pop, 0);
                check_val("busy_route", busy, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val($sformatf("push_dev%0d", e.dev), push, e.mask);
                    check_val($sformatf("d_push_dev%0d", e.dev), d_push, e.data);
                end
                prev_route = 1'b1;
            end
            if (pop != '0) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_pop", pop, 0);
                end else begin
                    check_val("pop_dev", pop, 32'(1) << exp_q[0].dev);
                    check_val("grant_id", grant_id, exp_q[0].dev);
                    check_val("busy_pop", busy, 1);
                    check_val("push_in_pop", push, 0);
                    if (chk_gap && last_pop_cyc >= 0) check_val("pop_gap", cyc - last_pop_cyc, 3);
                    if (chk_lat) check_val("pop_latency", cyc - pnd_on_cyc, 1);
                end
                last_pop_cyc = cyc;
            end
            prev_pop = pop;

            @(posedge clk);
            #1;
            old_pnd = pndng;
            for (int i = 0; i < ND; i++) begin
                if (snap[i] && dq_rd[i] != dq_wr[i]) dq_rd[i]++;
                pndng[i] = (dq_rd[i] != dq_wr[i]);
                d_pop[i] = pndng[i] ? dq[i][dq_rd[i] % 64] : 24'h0;
            end
            if (old_pnd == '0 && pndng != '0) pnd_on_cyc = cyc;
        end
    end

    // Stimulus
    initial begin
        logic [23:0] p;
        logic        found;
        rst_n = 1'b0;
        for (int i = 0; i < ND; i++) cfg_wght[i] = 4'd1;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_pop", pop, 0);
        check_val("rst_push", push, 0);
        check_val("rst_d_push", d_push, 0);
        check_val("rst_grant_id", grant_id, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // All devices pending, weight 1: strict rotation 0..15 twice, 3 cycles apart.
        last_pop_cyc = -1;
        chk_gap      = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < ND; i++) begin
                p = {8'((i + 1) % ND), 8'(r), 8'(i)};
                load_pkt(i, p);
                expect_pkt(i, p);
            end
        end
        drain("rotation_drain", 300);
        chk_gap = 1'b0;

        // Single unicast from device 3 to device 5.
        chk_lat = 1'b1;
        load_pkt(3, 24'h05ABCD);
        exp_q.push_back('{3, 16'h0020, 24'h05ABCD});
        drain("unicast_drain", 40);

        // Broadcast from device 2 skips the sender.
        load_pkt(2, 24'hFF1234);
        exp_q.push_back('{2, 16'hFFFB, 24'hFF1234});
        drain("bcast_drain", 40);
        chk_lat = 1'b0;
        check_val("drop_after_bcast", drop_cnt, 0);

        // Out-of-range and self-addressed packets are dropped but still shown on D_push.
        load_pkt(0, 24'h14BEEF);
        load_pkt(0, 24'h00CAFE);
        exp_q.push_back('{0, 16'h0000, 24'h14BEEF});
        exp_q.push_back('{0, 16'h0000, 24'h00CAFE});
        drain("drop_drain", 60);
        check_val("drop_cnt_two", drop_cnt, 2);

        // Weighted: device 1 weight 3, device 4 weight 1 -> 1,1,1,4,1,1,1,4.
        cfg_wght[1] = 4'd3;
        cfg_wght[4] = 4'd1;
        for (int k = 0; k < 6; k++) load_pkt(1, {8'h06, 8'h10, 8'(k)});
        for (int k = 0; k < 2; k++) load_pkt(4, {8'hFF, 8'h40, 8'(k)});
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) expect_pkt(1, {8'h06, 8'h10, 8'(b * 3 + k)});
            expect_pkt(4, {8'hFF, 8'h40, 8'(b)});
        end
        drain("weighted_drain", 120);
        cfg_wght[1] = 4'd1;

        // Reset while device 7 is in POP.
        load_pkt(7, 24'h017777);
        expect_pkt(7, 24'h017777);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #2;
            if (pop[7]) begin
                found = 1'b1;
                break;
            end
        end
        check_val("pop7_seen", found, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_pop", pop, 0);
        check_val("midrst_push", push, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_grant_id", grant_id, 0);
        check_val("midrst_drop_cnt", drop_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        load_pkt(2, 24'h052222);
        expect_pkt(2, 24'h052222);
        expect_pkt(7, 24'h017777);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain("post_reset_drain", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
